// File: rtl/ready_wait_generator_if.sv
// Command/ready bundle between the arbitrated bus side and the ready/wait-state generator.
interface ready_wait_generator_if;
    logic io_read_n;
    logic io_write_n;
    logic memory_read_n;
    logic memory_write_n;
    logic address_enable_n;
    logic dma_acknowledge_0_n;
    logic io_channel_ready;
    logic processor_ready;
    logic dma_ready;
    logic timeout_flag;

    modport master (
        output io_read_n, io_write_n, memory_read_n, memory_write_n,
        output address_enable_n, dma_acknowledge_0_n, io_channel_ready,
        input  processor_ready, dma_ready, timeout_flag
    );

    modport slave (
        input  io_read_n, io_write_n, memory_read_n, memory_write_n,
        input  address_enable_n, dma_acknowledge_0_n, io_channel_ready,
        output processor_ready, dma_ready, timeout_flag
    );
endinterface

// File: rtl/ready_wait_generator.sv
// Ready/wait-state generator: stretches CPU READY or DMA ready per cycle type and while
// synchronized channel ready is low. Build macro CHANNEL_READY_TIMEOUT_EN adds a watchdog.
//
// state        | meaning
// IDLE         | no cycle in progress, waiting for a command falling edge
// WAIT_COUNT   | inserting the programmed wait states
// WAIT_CHANNEL | holding the target ready low until channel ready (or watchdog)
// DONE         | target released, waiting for the command to end
module ready_wait_generator #(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned DMA_WAIT_STATES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    ready_wait_generator_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_COUNT,
        ST_WAIT_CHANNEL,
        ST_DONE
    } state_t;

    localparam logic [3:0] IO_COUNT  = 4'(IO_WAIT_STATES);
    localparam logic [3:0] DMA_COUNT = 4'(DMA_WAIT_STATES);
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       tgt_dma_q, tgt_dma_d;
    logic       proc_rdy_q, proc_rdy_d;
    logic       dma_rdy_q, dma_rdy_d;
    logic       cmd_prev_q;
    logic       ch_meta_q, ch_rdy_q;
    logic       cmd_active, start, is_refresh, is_dma, is_io;
    logic [3:0] load_count;
    logic       tgt_rdy_d;
    logic       timeout_hit;

    assign cmd_active = ~(bus.io_read_n & bus.io_write_n & bus.memory_read_n & bus.memory_write_n);
    assign start      = cmd_active & ~cmd_prev_q;
    assign is_dma     = bus.address_enable_n;
    assign is_refresh = bus.address_enable_n & ~bus.dma_acknowledge_0_n;
    assign is_io      = ~bus.io_read_n | ~bus.io_write_n;
    assign load_count = is_dma ? DMA_COUNT : (is_io ? IO_COUNT : 4'd0);

`ifdef CHANNEL_READY_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;

    assign timeout_hit = (wdog_q == WDOG_LAST);

    // Held at zero outside WAIT_CHANNEL so it always starts from zero on entry.
    always_comb begin
        wdog_d = 8'd0;
        if (state_q == ST_WAIT_CHANNEL) begin
            wdog_d = (wdog_q != 8'hFF) ? wdog_q + 8'd1 : wdog_q;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (state_q == ST_WAIT_CHANNEL && cmd_active && !ch_rdy_q && timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_flag = timeout_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^WDOG_LAST;
    assign bus.timeout_flag   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tgt_dma_d = tgt_dma_q;
        tgt_rdy_d = tgt_dma_q ? dma_rdy_q : proc_rdy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !is_refresh) begin
                    tgt_dma_d = is_dma;
                    count_d   = load_count;
                    if (load_count != 4'd0) begin
                        state_d   = ST_WAIT_COUNT;
                        tgt_rdy_d = 1'b0;
                    end else begin
                        state_d   = ST_WAIT_CHANNEL;
                        tgt_rdy_d = ch_rdy_q;
                    end
                end
            end
            ST_WAIT_COUNT: begin
                count_d = (count_q != 4'd0) ? count_q - 4'd1 : 4'd0;
                if (!cmd_active) begin
                    state_d   = ST_IDLE;
                    tgt_rdy_d = 1'b1;
                end else if (count_q == 4'd1) begin
                    if (ch_rdy_q) begin
                        state_d   = ST_DONE;
                        tgt_rdy_d = 1'b1;
                    end else begin
                        state_d   = ST_WAIT_CHANNEL;
                        tgt_rdy_d = 1'b0;
                    end
                end
            end
            ST_WAIT_CHANNEL: begin
                if (!cmd_active) begin
                    state_d   = ST_IDLE;
                    tgt_rdy_d = 1'b1;
                end else if (ch_rdy_q || timeout_hit) begin
                    state_d   = ST_DONE;
                    tgt_rdy_d = 1'b1;
                end else begin
                    tgt_rdy_d = 1'b0;
                end
            end
            ST_DONE: begin
                // No start is honoured here, so a long command cannot retrigger.
                tgt_rdy_d = 1'b1;
                if (!cmd_active) state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                tgt_rdy_d = 1'b1;
            end
        endcase
        proc_rdy_d = tgt_dma_d ? 1'b1 : tgt_rdy_d;
        dma_rdy_d  = tgt_dma_d ? tgt_rdy_d : 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            tgt_dma_q  <= 1'b0;
            proc_rdy_q <= 1'b1;
            dma_rdy_q  <= 1'b1;
            cmd_prev_q <= 1'b0;
            ch_meta_q  <= 1'b1;
            ch_rdy_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            tgt_dma_q  <= tgt_dma_d;
            proc_rdy_q <= proc_rdy_d;
            dma_rdy_q  <= dma_rdy_d;
            cmd_prev_q <= cmd_active;
            ch_meta_q  <= bus.io_channel_ready;
            ch_rdy_q   <= ch_meta_q;
        end
    end

    assign bus.processor_ready = proc_rdy_q;
    assign bus.dma_ready       = dma_rdy_q;

endmodule

// File: tb/tb_ready_wait_generator.sv
// Bench for ready_wait_generator: vector table, corner sequences, random run vs timeline model.
module tb_ready_wait_generator;
    localparam int IO_A = 1, DMA_A = 2, TMO_A = 8;
    localparam int IO_B = 4, DMA_B = 1, TMO_B = 20;
    localparam int CFG_IO [2] = '{IO_A, IO_B};
    localparam int CFG_DMA[2] = '{DMA_A, DMA_B};
    localparam int CFG_TMO[2] = '{TMO_A, TMO_B};
`ifdef CHANNEL_READY_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cmd_n = 4'hF;  // {io_read_n, io_write_n, memory_read_n, memory_write_n}
    logic       aen_n = 1'b0, dack0_n = 1'b1, ch_in = 1'b1;
    int         n_checks = 0, n_fail = 0;

    ready_wait_generator_if if_a ();
    ready_wait_generator_if if_b ();

    assign if_a.io_read_n = cmd_n[3];          assign if_b.io_read_n = cmd_n[3];
    assign if_a.io_write_n = cmd_n[2];         assign if_b.io_write_n = cmd_n[2];
    assign if_a.memory_read_n = cmd_n[1];      assign if_b.memory_read_n = cmd_n[1];
    assign if_a.memory_write_n = cmd_n[0];     assign if_b.memory_write_n = cmd_n[0];
    assign if_a.address_enable_n = aen_n;      assign if_b.address_enable_n = aen_n;
    assign if_a.dma_acknowledge_0_n = dack0_n; assign if_b.dma_acknowledge_0_n = dack0_n;
    assign if_a.io_channel_ready = ch_in;      assign if_b.io_channel_ready = ch_in;

    ready_wait_generator #(.IO_WAIT_STATES(IO_A), .DMA_WAIT_STATES(DMA_A), .TIMEOUT_CYCLES(TMO_A))
        dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    ready_wait_generator #(.IO_WAIT_STATES(IO_B), .DMA_WAIT_STATES(DMA_B), .TIMEOUT_CYCLES(TMO_B))
        dut_b (.clock(clock), .reset(reset), .bus(if_b.slave));

    always #5 clock = ~clock;

    // Timeline model: a cycle opens at its start edge, ready is low until the first edge
    // at or after start+need where channel ready is seen, or the watchdog edge.
    bit chq[$];
    bit m_prev;
    int k;
    bit m_cyc[2], m_rel[2], m_dma[2], m_flag[2], exp_p[2], exp_d[2];
    int m_need[2], m_from[2], m_tmo_at[2];

    task automatic model_reset();
        chq = '{1'b1, 1'b1};
        m_prev = 1'b0;
        k = 0;
        for (int d = 0; d < 2; d++) begin
            m_cyc[d] = 0; m_rel[d] = 0; m_dma[d] = 0; m_flag[d] = 0;
            exp_p[d] = 1; exp_d[d] = 1;
        end
    endtask

    task automatic model_edge();
        bit chr, active, start, low;
        chr = chq.pop_front();
        chq.push_back(ch_in);
        active = (cmd_n != 4'hF);
        start = active && !m_prev;
        for (int d = 0; d < 2; d++) begin
            if (m_cyc[d] && !active) m_cyc[d] = 0;
            if (start && !(aen_n && !dack0_n)) begin
                m_cyc[d] = 1;
                m_rel[d] = 0;
                m_dma[d] = aen_n;
                m_need[d] = aen_n ? CFG_DMA[d] : ((!cmd_n[3] || !cmd_n[2]) ? CFG_IO[d] : 0);
                m_from[d] = (m_need[d] > 0) ? k + m_need[d] : k + 1;
                m_tmo_at[d] = k + m_need[d] + CFG_TMO[d];
            end
            low = 0;
            if (m_cyc[d] && !m_rel[d]) begin
                if (k < m_from[d]) low = (m_need[d] > 0) || !chr;
                else if (chr) m_rel[d] = 1;
                else if (TMO_ON && k == m_tmo_at[d]) begin
                    m_rel[d] = 1;
                    m_flag[d] = 1;
                end else low = 1;
            end
            exp_p[d] = !(low && !m_dma[d]);
            exp_d[d] = !(low && m_dma[d]);
        end
        m_prev = active;
        k++;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) model_reset();
        else model_edge();
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " a.prdy"}, if_a.processor_ready, exp_p[0]);
        chk({tag, " a.drdy"}, if_a.dma_ready, exp_d[0]);
        chk({tag, " a.tmo"}, if_a.timeout_flag, m_flag[0]);
        chk({tag, " b.prdy"}, if_b.processor_ready, exp_p[1]);
        chk({tag, " b.drdy"}, if_b.dma_ready, exp_d[1]);
        chk({tag, " b.tmo"}, if_b.timeout_flag, m_flag[1]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " a.prdy"}, if_a.processor_ready, 1'b1);
        chk({tag, " a.drdy"}, if_a.dma_ready, 1'b1);
        chk({tag, " a.tmo"}, if_a.timeout_flag, 1'b0);
        chk({tag, " b.prdy"}, if_b.processor_ready, 1'b1);
        chk({tag, " b.drdy"}, if_b.dma_ready, 1'b1);
        chk({tag, " b.tmo"}, if_b.timeout_flag, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [3:0] c, input logic a, input logic dk, input logic ch);
        cmd_n = c; aen_n = a; dack0_n = dk; ch_in = ch;
    endtask

    typedef struct {
        logic [3:0] cmd;
        logic       aen, dack, ch;
        int         reps;
        logic       p, d;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        // Expected outputs of dut_a (IO=1, DMA=2) after the edge that samples each row.
        vecs[0]  = '{4'hF, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1};
        vecs[1]  = '{4'h7, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};  // I/O read: one wait
        vecs[2]  = '{4'h7, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1};
        vecs[3]  = '{4'hF, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[4]  = '{4'hD, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0};  // DMA read: two waits
        vecs[5]  = '{4'hD, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[6]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[7]  = '{4'hD, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1};  // refresh: no waits
        vecs[8]  = '{4'hD, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vecs[9]  = '{4'hF, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vecs[10] = '{4'hE, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1};  // mem write stretched by channel
        vecs[11] = '{4'hE, 1'b0, 1'b1, 1'b1, 2, 1'b0, 1'b1};
        vecs[12] = '{4'hE, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[13] = '{4'hF, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[14] = '{4'hB, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1};  // long I/O write: no retrigger
        vecs[15] = '{4'hB, 1'b0, 1'b1, 1'b1, 9, 1'b1, 1'b1};
        vecs[16] = '{4'hF, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[17] = '{4'hD, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0};  // AEN drops mid DMA: ignored
        vecs[18] = '{4'hD, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0};
        vecs[19] = '{4'hD, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};
        vecs[20] = '{4'hF, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1};

        repeat (3) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;
        step();
        chk_reset_vals("idle");

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                drive(vecs[i].cmd, vecs[i].aen, vecs[i].dack, vecs[i].ch);
                step();
                chk($sformatf("vec%0d.%0d prdy", i, r), if_a.processor_ready, vecs[i].p);
                chk($sformatf("vec%0d.%0d drdy", i, r), if_a.dma_ready, vecs[i].d);
                chk($sformatf("vec%0d.%0d tmo", i, r), if_a.timeout_flag, 1'b0);
            end
        end

        // Four I/O waits on dut_b, one on dut_a, from the same command.
        drive(4'h7, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("io4 b.prdy %0d", i), if_b.processor_ready, logic'(i >= 4));
            chk($sformatf("io1 a.prdy %0d", i), if_a.processor_ready, logic'(i >= 1));
        end
        drive(4'hF, 1'b0, 1'b1, 1'b1);
        step();

        // Abort during the counted waits.
        drive(4'h7, 1'b0, 1'b1, 1'b1);
        repeat (3) step();
        chk("abort pre b.prdy", if_b.processor_ready, 1'b0);
        drive(4'hF, 1'b0, 1'b1, 1'b1);
        step();
        chk("abort b.prdy", if_b.processor_ready, 1'b1);
        chk("abort b.drdy", if_b.dma_ready, 1'b1);

        // Asynchronous reset in the middle of the counted waits.
        drive(4'h7, 1'b0, 1'b1, 1'b1);
        step();
        step();
        chk("pre-reset b.prdy", if_b.processor_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk_reset_vals("async reset");
        drive(4'hF, 1'b0, 1'b1, 1'b1);
        step();
        reset = 1'b0;
        step();
        chk_reset_vals("post reset");
        drive(4'h7, 1'b0, 1'b1, 1'b1);
        step();
        chk("restart b.prdy", if_b.processor_ready, 1'b0);
        drive(4'hF, 1'b0, 1'b1, 1'b1);
        step();

        // Channel ready stuck low on a memory cycle.
        drive(4'hF, 1'b0, 1'b1, 1'b0);
        step();
        step();
        drive(4'hE, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("stuck a.prdy %0d", i), if_a.processor_ready, TMO_ON && (i >= 8));
            chk($sformatf("stuck a.tmo %0d", i), if_a.timeout_flag, TMO_ON && (i >= 8));
        end
        drive(4'hF, 1'b0, 1'b1, 1'b1);
        step();
        chk("stuck end a.prdy", if_a.processor_ready, 1'b1);
        chk("stuck end a.tmo", if_a.timeout_flag, TMO_ON);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("tmo cleared a.tmo", if_a.timeout_flag, 1'b0);

        // Random traffic against the timeline model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 6))
                    0, 1:    cmd_n = 4'hF;
                    2:       cmd_n = 4'h7;
                    3:       cmd_n = 4'hB;
                    4:       cmd_n = 4'hD;
                    5:       cmd_n = 4'hE;
                    default: cmd_n = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 7) == 0) aen_n = ~aen_n;
            if ($urandom_range(0, 5) == 0) dack0_n = ~dack0_n;
            if ($urandom_range(0, 9) == 0) ch_in = ~ch_in;
            step();
            chk_model($sformatf("rand%0d", i));
            if (i == 700) begin
                reset = 1'b1;
                #1;
                chk_model("rand reset");
                #1;
                reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
